// File: rtl/sym_byte_packer_pkg.sv
// Shared constants and state type for the 3-bit symbol to byte packer.
// Imported by the packer top module.
package sym_byte_packer_pkg;

   localparam int SYM_W  = 3;
   localparam int BYTE_W = 8;
   localparam int ACC_W  = 10;
   localparam int CNT_W  = 4;
   localparam int PAD_W  = 3;

   typedef enum logic {
      ACCUM = 1'b0,
      FLUSH = 1'b1
   } state_e;

endpackage

// File: rtl/sym_byte_packer.sv
// Packs 3-bit symbols LSB-first into bytes; the final byte of a packet
// carries m_last and the count of zero pad bits at its upper end.
module sym_byte_packer
   import sym_byte_packer_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [SYM_W-1:0] s_data,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [BYTE_W-1:0] m_data,
   output logic             m_last,
   output logic [PAD_W-1:0] m_pad
);

   localparam logic [CNT_W-1:0] CNT_SYM  = CNT_W'(SYM_W);
   localparam logic [CNT_W-1:0] CNT_BYTE = CNT_W'(BYTE_W);

   state_e              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                m_valid_q, m_valid_d;
   logic [BYTE_W-1:0]   m_data_q, m_data_d;
   logic                m_last_q, m_last_d;
   logic [PAD_W-1:0]    m_pad_q, m_pad_d;

   logic                out_free;
   logic                accept;
   logic                full;
   logic [ACC_W-1:0]    sym_ext;
   logic [CNT_W-1:0]    pad_cnt;

   assign s_ready  = (state_q == ACCUM) && (cnt_q < CNT_BYTE);
   assign out_free = !m_valid_q || m_ready;
   assign accept   = s_valid && s_ready;
   assign full     = (cnt_q >= CNT_BYTE);
   assign sym_ext  = {{(ACC_W-SYM_W){1'b0}}, s_data};
   assign pad_cnt  = CNT_BYTE - cnt_q;

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_last  = m_last_q;
   assign m_pad   = m_pad_q;

   // Next-state: accumulate symbols, emit full bytes, close the packet in FLUSH.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      m_valid_d = m_valid_q && !m_ready;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
      m_pad_d   = m_pad_q;

      unique case (state_q)
         ACCUM: begin
            if (accept) begin
               acc_d = acc_q | (sym_ext << cnt_q);
               cnt_d = cnt_q + CNT_SYM;
               if (s_last) begin
                  state_d = FLUSH;
               end
            end else if (full && out_free) begin
               m_valid_d = 1'b1;
               m_data_d  = acc_q[BYTE_W-1:0];
               m_last_d  = 1'b0;
               m_pad_d   = '0;
               acc_d     = acc_q >> BYTE_W;
               cnt_d     = cnt_q - CNT_BYTE;
            end
         end
         FLUSH: begin
            if (out_free) begin
               if (full) begin
                  m_valid_d = 1'b1;
                  m_data_d  = acc_q[BYTE_W-1:0];
                  m_pad_d   = '0;
                  acc_d     = acc_q >> BYTE_W;
                  cnt_d     = cnt_q - CNT_BYTE;
                  m_last_d  = (cnt_q == CNT_BYTE);
                  if (cnt_q == CNT_BYTE) begin
                     state_d = ACCUM;
                  end
               end else if (cnt_q != '0) begin
                  m_valid_d = 1'b1;
                  m_data_d  = acc_q[BYTE_W-1:0];
                  m_last_d  = 1'b1;
                  m_pad_d   = pad_cnt[PAD_W-1:0];
                  acc_d     = '0;
                  cnt_d     = '0;
                  state_d   = ACCUM;
               end else begin
                  // Nothing left to flush; a packet never ends here with data held.
                  state_d = ACCUM;
               end
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ACCUM;
         acc_q     <= '0;
         cnt_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         m_pad_q   <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
         m_pad_q   <= m_pad_d;
      end
   end

endmodule

// File: tb/tb_sym_byte_packer.sv
// Directed self-checking bench for sym_byte_packer.
// Linear sequence of steps with hand-computed expected bytes.
module tb_sym_byte_packer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s_valid;
   logic       s_ready;
   logic [2:0] s_data;
   logic       s_last;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       m_last;
   logic [2:0] m_pad;

   int checks   = 0;
   int failures = 0;

   logic [7:0] q_data[$];
   logic       q_last[$];
   logic [2:0] q_pad[$];

   int sent;
   int cyc;
   bit done;
   bit acc_now;

   sym_byte_packer dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last),
      .m_pad   (m_pad)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_byte(input string tag, input logic [7:0] d,
                           input logic l, input logic [2:0] p);
      chk({tag, "_valid"}, 32'(m_valid), 32'd1);
      chk({tag, "_data"}, 32'(m_data), 32'(d));
      chk({tag, "_last"}, 32'(m_last), 32'(l));
      chk({tag, "_pad"}, 32'(m_pad), 32'(p));
   endtask

   task automatic send(input string tag, input logic [2:0] d,
                       input logic l);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      chk({tag, "_sready"}, 32'(s_ready), 32'd1);
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      tick();
      tick();
      chk("rst_mvalid", 32'(m_valid), 32'd0);
      chk("rst_mdata", 32'(m_data), 32'd0);
      chk("rst_mlast", 32'(m_last), 32'd0);
      chk("rst_mpad", 32'(m_pad), 32'd0);
      chk("rst_sready", 32'(s_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // Single-symbol packet
      m_ready = 1'b1;
      send("one_sym", 3'b110, 1'b1);
      chk("one_flush_sready", 32'(s_ready), 32'd0);
      chk("one_lat_mvalid", 32'(m_valid), 32'd0);
      tick();
      chk_byte("one_byte", 8'h06, 1'b1, 3'd5);
      chk("one_back_sready", 32'(s_ready), 32'd1);
      tick();
      chk("one_drain", 32'(m_valid), 32'd0);

      // Three-symbol packet
      send("three_a", 3'b101, 1'b0);
      send("three_b", 3'b010, 1'b0);
      send("three_c", 3'b111, 1'b1);
      chk("three_lat", 32'(m_valid), 32'd0);
      tick();
      chk_byte("three_b0", 8'hD5, 1'b0, 3'd0);
      tick();
      chk_byte("three_b1", 8'h01, 1'b1, 3'd7);
      tick();
      chk("three_drain", 32'(m_valid), 32'd0);

      // Exact-fit streaming packet with throughput timing
      q_data.delete();
      q_last.delete();
      q_pad.delete();
      sent = 0;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 40) begin
         s_valid = (sent < 8);
         s_data  = 3'b111;
         s_last  = (sent == 7);
         acc_now = s_valid && s_ready;
         if (m_valid && m_ready) begin
            q_data.push_back(m_data);
            q_last.push_back(m_last);
            q_pad.push_back(m_pad);
            if (m_last) done = 1'b1;
         end
         tick();
         cyc++;
         if (acc_now) sent++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk("fit_done", 32'(done), 32'd1);
      chk("fit_cycles", 32'(cyc), 32'd12);
      chk("fit_sent", 32'(sent), 32'd8);
      chk("fit_nbytes", 32'(q_data.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("fit_d%0d", i), 32'(q_data[i]), 32'hFF);
         chk($sformatf("fit_l%0d", i), 32'(q_last[i]), 32'(i == 2));
         chk($sformatf("fit_p%0d", i), 32'(q_pad[i]), 32'd0);
      end
      chk("fit_sready", 32'(s_ready), 32'd1);

      // Backpressure with a byte pending
      m_ready = 1'b0;
      send("bp_a", 3'b001, 1'b0);
      send("bp_b", 3'b010, 1'b0);
      send("bp_c", 3'b011, 1'b0);
      chk("bp_full_sready", 32'(s_ready), 32'd0);
      tick();
      chk_byte("bp_b0", 8'hD1, 1'b0, 3'd0);
      send("bp_d", 3'b100, 1'b0);
      chk_byte("bp_hold1", 8'hD1, 1'b0, 3'd0);
      send("bp_e", 3'b101, 1'b0);
      chk_byte("bp_hold2", 8'hD1, 1'b0, 3'd0);
      send("bp_f", 3'b110, 1'b1);
      chk_byte("bp_hold3", 8'hD1, 1'b0, 3'd0);
      chk("bp_sready0", 32'(s_ready), 32'd0);
      tick();
      chk_byte("bp_hold4", 8'hD1, 1'b0, 3'd0);
      tick();
      chk_byte("bp_hold5", 8'hD1, 1'b0, 3'd0);
      chk("bp_sready1", 32'(s_ready), 32'd0);
      m_ready = 1'b1;
      tick();
      chk_byte("bp_b1", 8'h58, 1'b0, 3'd0);
      tick();
      chk_byte("bp_b2", 8'h03, 1'b1, 3'd6);
      tick();
      chk("bp_drain", 32'(m_valid), 32'd0);
      chk("bp_sready2", 32'(s_ready), 32'd1);

      // Reset while in FLUSH
      send("rf_a", 3'b101, 1'b1);
      chk("rf_in_flush", 32'(s_ready), 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rf_mvalid", 32'(m_valid), 32'd0);
      chk("rf_mlast", 32'(m_last), 32'd0);
      chk("rf_sready", 32'(s_ready), 32'd1);
      tick();
      chk("rf_nobyte1", 32'(m_valid), 32'd0);
      tick();
      chk("rf_nobyte2", 32'(m_valid), 32'd0);
      chk("rf_sready2", 32'(s_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
